dsp_mac_unit: RTL and testbench

- Responder end of the decode-stage DSP request interface.
- Accepts a start pulse, a 2-bit DSP opcode, both register operands and the destination register from decode.
- Runs an iterative multiply or multiply-accumulate over several cycles and raises a busy stall toward the pipeline.
- Returns a one-cycle done pulse with result, destination register and register-write enable toward writeback.

---
 rtl/dsp_pkg.sv | 21 ++
 rtl/dsp_mul_core.sv | 79 +++++++
 rtl/dsp_mac_unit.sv | 155 +++++++++++++++
 tb/tb_dsp_mac_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared opcodes, FSM states and iteration-count derivation for the DSP MAC unit
package dsp_pkg;

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULH  = 2'b01;
   localparam logic [1:0] OP_MULHU = 2'b10;
   localparam logic [1:0] OP_MAC   = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } dsp_state_e;

   // Multiplier iterations: one STEP_BITS-wide slice of operand B per cycle.
   function automatic int dsp_iters(input int data_w, input int step_bits);
      return data_w / step_bits;
   endfunction

endpackage

// File: rtl/dsp_mul_core.sv
// rtl/dsp_mul_core.sv - iterative unsigned shift-add multiplier, STEP_BITS multiplier bits per step
//
// Ports:
//   clk_i, rst_ni   clock and asynchronous active-low reset
//   load_i          latch operands, clear product, reload iteration counter
//   step_i          retire one slice of b (MSB-first)
//   a_i             DATA_W+1 bit unsigned magnitude (covers |0x80000000|)
//   b_i             DATA_W bit unsigned magnitude
//   prod_o          2*DATA_W bit product
//   last_o          high while the final step is pending
module dsp_mul_core
   import dsp_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int STEP_BITS = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  load_i,
   input  logic                  step_i,
   input  logic [DATA_W:0]       a_i,
   input  logic [DATA_W-1:0]     b_i,
   output logic [2*DATA_W-1:0]   prod_o,
   output logic                  last_o
);

   localparam int ITERS = dsp_iters(DATA_W, STEP_BITS);
   localparam int CNT_W = $clog2(ITERS + 1);
   localparam int PW    = 2 * DATA_W;

   logic [DATA_W:0]     a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [PW-1:0]       prod_q, prod_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic [PW-1:0]       a_ext;
   logic [PW-1:0]       nib_ext;
   logic [PW-1:0]       pp;

   // Horner form: prod = prod * 2^STEP_BITS + slice * a, consuming b from its top slice.
   assign a_ext   = {{(PW-DATA_W-1){1'b0}}, a_q};
   assign nib_ext = {{(PW-STEP_BITS){1'b0}}, b_q[DATA_W-1 -: STEP_BITS]};
   assign pp      = a_ext * nib_ext;

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      prod_d = prod_q;
      cnt_d  = cnt_q;
      if (load_i) begin
         a_d    = a_i;
         b_d    = b_i;
         prod_d = '0;
         cnt_d  = CNT_W'(ITERS - 1);
      end else if (step_i) begin
         prod_d = (prod_q << STEP_BITS) + pp;
         b_d    = b_q << STEP_BITS;
         cnt_d  = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
         cnt_q  <= '0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         prod_q <= prod_d;
         cnt_q  <= cnt_d;
      end
   end

   assign prod_o = prod_q;
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/dsp_mac_unit.sv
// rtl/dsp_mac_unit.sv - decode-side DSP responder: iterative MUL/MULH/MULHU/MAC with busy stall
//
// Ports:
//   i_clk, i_reset        clock and asynchronous active-low reset
//   i_start_dsp           request strobe, sampled in IDLE/DONE
//   i_op_dsp              00 MUL, 01 MULH, 10 MULHU, 11 MAC
//   i_register1/2         operands A and B
//   i_WriteReg            destination register
//   i_acc_clr             accumulator clear, honoured in IDLE/DONE
//   o_busy                pipeline stall (CALC/FIX)
//   o_done, o_RegWrite    one-cycle result-valid pulse
//   o_result, o_WriteReg  result word and destination, held until next FIX
module dsp_mac_unit
   import dsp_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int STEP_BITS = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start_dsp,
   input  logic [1:0]        i_op_dsp,
   input  logic [DATA_W-1:0] i_register1,
   input  logic [DATA_W-1:0] i_register2,
   input  logic [4:0]        i_WriteReg,
   input  logic              i_acc_clr,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_result,
   output logic [4:0]        o_WriteReg,
   output logic              o_RegWrite
);

   localparam int PW = 2 * DATA_W;
   localparam logic [DATA_W:0]   ONE_A = {{DATA_W{1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] ONE_B = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]     ONE_P = {{(PW-1){1'b0}}, 1'b1};

   dsp_state_e        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic              sign_q, sign_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [4:0]        wreg_q, wreg_d;

   logic              core_load;
   logic              core_step;
   logic              core_last;
   logic [PW-1:0]     core_prod;

   logic              in_mulh;
   logic [DATA_W:0]   a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [PW-1:0]     prod_fix;
   logic [DATA_W-1:0] word_sel;

   // Only MULH treats operands as signed. A is sign-extended to DATA_W+1 bits before
   // negation so that the most negative value yields its true magnitude 2^(DATA_W-1).
   assign in_mulh = (i_op_dsp == OP_MULH);
   assign a_mag   = (in_mulh && i_register1[DATA_W-1])
                    ? (~{i_register1[DATA_W-1], i_register1} + ONE_A)
                    : {1'b0, i_register1};
   assign b_mag   = (in_mulh && i_register2[DATA_W-1])
                    ? (~i_register2 + ONE_B)
                    : i_register2;

   assign prod_fix = sign_q ? (~core_prod + ONE_P) : core_prod;
   assign word_sel = ((op_q == OP_MULH) || (op_q == OP_MULHU))
                     ? prod_fix[PW-1:DATA_W]
                     : prod_fix[DATA_W-1:0];

   dsp_mul_core #(
      .DATA_W    (DATA_W),
      .STEP_BITS (STEP_BITS)
   ) u_core (
      .clk_i  (i_clk),
      .rst_ni (i_reset),
      .load_i (core_load),
      .step_i (core_step),
      .a_i    (a_mag),
      .b_i    (b_mag),
      .prod_o (core_prod),
      .last_o (core_last)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rd_d      = rd_q;
      sign_d    = sign_q;
      acc_d     = acc_q;
      result_d  = result_q;
      wreg_d    = wreg_q;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            // Clear lands before a MAC started on the same edge reaches FIX.
            if (i_acc_clr) acc_d = '0;
            if (i_start_dsp) begin
               state_d   = CALC;
               op_d      = i_op_dsp;
               rd_d      = i_WriteReg;
               sign_d    = in_mulh && (i_register1[DATA_W-1] ^ i_register2[DATA_W-1]);
               core_load = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            core_step = 1'b1;
            if (core_last) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            wreg_d  = rd_q;
            if (op_q == OP_MAC) begin
               acc_d    = acc_q + word_sel;
               result_d = acc_q + word_sel;
            end else begin
               result_d = word_sel;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= IDLE;
         op_q     <= OP_MUL;
         rd_q     <= '0;
         sign_q   <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
         wreg_q   <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         sign_q   <= sign_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         wreg_q   <= wreg_d;
      end
   end

   assign o_busy     = (state_q == CALC) || (state_q == FIX);
   assign o_done     = (state_q == DONE);
   assign o_RegWrite = (state_q == DONE);
   assign o_result   = result_q;
   assign o_WriteReg = wreg_q;

endmodule

// File: tb/tb_dsp_mac_unit.sv
// tb/tb_dsp_mac_unit.sv - directed self-checking bench for dsp_mac_unit
module tb_dsp_mac_unit;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_start_dsp = 1'b0;
   logic [1:0]  i_op_dsp = 2'b00;
   logic [31:0] i_register1 = '0;
   logic [31:0] i_register2 = '0;
   logic [4:0]  i_WriteReg = '0;
   logic        i_acc_clr = 1'b0;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;
   logic [4:0]  o_WriteReg;
   logic        o_RegWrite;

   int errors = 0;
   int checks = 0;

   dsp_mac_unit dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_start_dsp (i_start_dsp),
      .i_op_dsp    (i_op_dsp),
      .i_register1 (i_register1),
      .i_register2 (i_register2),
      .i_WriteReg  (i_WriteReg),
      .i_acc_clr   (i_acc_clr),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_result    (o_result),
      .o_WriteReg  (o_WriteReg),
      .o_RegWrite  (o_RegWrite)
   );

   always #5 i_clk = ~i_clk;

   // Drives one request (sampled on the next edge), then waits for o_done.
   // lat counts edges from the sampling edge up to the one that raises o_done.
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic clr,
                        output int lat, output int busy_cnt,
                        output logic [31:0] res, output logic [4:0] wr, output logic rw);
      i_start_dsp = 1'b1;
      i_op_dsp    = op;
      i_register1 = a;
      i_register2 = b;
      i_WriteReg  = rd;
      i_acc_clr   = clr;
      @(posedge i_clk); #1;
      i_start_dsp = 1'b0;
      i_acc_clr   = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!o_done && lat < 40) begin
         if (o_busy) busy_cnt++;
         @(posedge i_clk); #1;
         lat++;
      end
      res = o_result;
      wr  = o_WriteReg;
      rw  = o_RegWrite;
   endtask

   task automatic test_reset();
      i_reset = 1'b0;
      #12;
      checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
      checks++; if (o_done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
      checks++; if (o_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %b want 0", o_RegWrite); end
      checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", o_result); end
      checks++; if (o_WriteReg !== 5'd0) begin errors++; $display("FAIL reset_wreg: got %0d want 0", o_WriteReg); end
      @(posedge i_clk); #1;
      i_reset = 1'b1;
      @(posedge i_clk); #1;
   endtask

   task automatic test_mul();
      int lat, bc; logic [31:0] res; logic [4:0] wr; logic rw;
      do_op(2'b00, 32'd7, 32'd6, 5'd5, 1'b0, lat, bc, res, wr, rw);
      checks++; if (lat !== 10)       begin errors++; $display("FAIL mul_latency: got %0d want 10", lat); end
      checks++; if (bc !== 9)         begin errors++; $display("FAIL mul_busy_cycles: got %0d want 9", bc); end
      checks++; if (res !== 32'd42)   begin errors++; $display("FAIL mul_result: got %h want 2a", res); end
      checks++; if (wr !== 5'd5)      begin errors++; $display("FAIL mul_wreg: got %0d want 5", wr); end
      checks++; if (rw !== 1'b1)      begin errors++; $display("FAIL mul_regwrite: got %b want 1", rw); end
      @(posedge i_clk); #1;
      checks++; if (o_done !== 1'b0 || o_RegWrite !== 1'b0) begin errors++; $display("FAIL mul_pulse_width: done=%b rw=%b want 0 0", o_done, o_RegWrite); end
      checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL mul_idle_busy: got %b want 0", o_busy); end
      checks++; if (o_result !== 32'd42) begin errors++; $display("FAIL mul_result_hold: got %h want 2a", o_result); end
   endtask

   task automatic test_mulh();
      int lat, bc; logic [31:0] res; logic [4:0] wr; logic rw;
      do_op(2'b01, 32'hFFFFFFFE, 32'd3, 5'd1, 1'b0, lat, bc, res, wr, rw);
      checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulh_neg: got %h want ffffffff", res); end
      do_op(2'b01, 32'h80000000, 32'h80000000, 5'd2, 1'b0, lat, bc, res, wr, rw);
      checks++; if (res !== 32'h40000000) begin errors++; $display("FAIL mulh_minint: got %h want 40000000", res); end
      do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 1'b0, lat, bc, res, wr, rw);
      checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_max: got %h want fffffffe", res); end
      checks++; if (wr !== 5'd3)          begin errors++; $display("FAIL mulhu_wreg: got %0d want 3", wr); end
      @(posedge i_clk); #1;
   endtask

   task automatic test_back_to_back();
      int lat, bc; logic [31:0] res; logic [4:0] wr; logic rw;
      i_acc_clr = 1'b1;
      @(posedge i_clk); #1;
      i_acc_clr = 1'b0;
      do_op(2'b11, 32'd3, 32'd4, 5'd8, 1'b0, lat, bc, res, wr, rw);
      checks++; if (res !== 32'd12) begin errors++; $display("FAIL mac_first: got %h want c", res); end
      // Started in the DONE cycle: DONE goes straight to CALC.
      do_op(2'b11, 32'd5, 32'd5, 5'd9, 1'b0, lat, bc, res, wr, rw);
      checks++; if (res !== 32'd37) begin errors++; $display("FAIL mac_b2b_result: got %h want 25", res); end
      checks++; if (lat !== 10)     begin errors++; $display("FAIL mac_b2b_latency: got %0d want 10", lat); end
      checks++; if (bc !== 9)       begin errors++; $display("FAIL mac_b2b_busy: got %0d want 9", bc); end
      checks++; if (wr !== 5'd9)    begin errors++; $display("FAIL mac_b2b_wreg: got %0d want 9", wr); end
   endtask

   task automatic test_wrap();
      int lat, bc; logic [31:0] res; logic [4:0] wr; logic rw;
      do_op(2'b11, 32'd1, 32'hFFFFFFFF, 5'd4, 1'b1, lat, bc, res, wr, rw);
      checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL mac_preload: got %h want ffffffff", res); end
      do_op(2'b11, 32'd1, 32'd1, 5'd4, 1'b0, lat, bc, res, wr, rw);
      checks++; if (res !== 32'h0) begin errors++; $display("FAIL mac_wrap: got %h want 0", res); end
      do_op(2'b11, 32'd2, 32'd2, 5'd0, 1'b1, lat, bc, res, wr, rw);
      checks++; if (res !== 32'd4) begin errors++; $display("FAIL mac_clr_start: got %h want 4", res); end
      checks++; if (rw !== 1'b1 || wr !== 5'd0) begin errors++; $display("FAIL mac_rd0_report: rw=%b wr=%0d want 1 0", rw, wr); end
      @(posedge i_clk); #1;
   endtask

   task automatic test_ignored_start();
      int dones = 0;
      logic [31:0] res = '0;
      logic [4:0]  wr = '0;
      i_start_dsp = 1'b1; i_op_dsp = 2'b00; i_register1 = 32'd7; i_register2 = 32'd6; i_WriteReg = 5'd5;
      @(posedge i_clk); #1;
      i_start_dsp = 1'b0;
      repeat (3) begin @(posedge i_clk); #1; end
      i_start_dsp = 1'b1; i_register1 = 32'd9; i_register2 = 32'd9; i_WriteReg = 5'd7;
      @(posedge i_clk); #1;
      i_start_dsp = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (o_done) begin dones++; res = o_result; wr = o_WriteReg; end
         @(posedge i_clk); #1;
      end
      checks++; if (dones !== 1)     begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
      checks++; if (res !== 32'd42)  begin errors++; $display("FAIL ignore_result: got %h want 2a", res); end
      checks++; if (wr !== 5'd5)     begin errors++; $display("FAIL ignore_wreg: got %0d want 5", wr); end
   endtask

   task automatic test_reset_mid_calc();
      int lat, bc, dones; logic [31:0] res; logic [4:0] wr; logic rw;
      dones = 0;
      i_start_dsp = 1'b1; i_op_dsp = 2'b00; i_register1 = 32'd11; i_register2 = 32'd13; i_WriteReg = 5'd6;
      @(posedge i_clk); #1;
      i_start_dsp = 1'b0;
      repeat (3) begin @(posedge i_clk); #1; end
      checks++; if (o_busy !== 1'b1)  begin errors++; $display("FAIL rst_pre_busy: got %b want 1", o_busy); end
      i_reset = 1'b0;
      #1;
      checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL rst_async_busy: got %b want 0", o_busy); end
      checks++; if (o_result !== 32'h0) begin errors++; $display("FAIL rst_async_result: got %h want 0", o_result); end
      @(posedge i_clk); #1;
      i_reset = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (o_done) dones++;
         @(posedge i_clk); #1;
      end
      checks++; if (dones !== 0) begin errors++; $display("FAIL rst_no_done: got %0d want 0", dones); end
      do_op(2'b00, 32'd2, 32'd3, 5'd10, 1'b0, lat, bc, res, wr, rw);
      checks++; if (res !== 32'd6) begin errors++; $display("FAIL rst_after_result: got %h want 6", res); end
      checks++; if (lat !== 10)    begin errors++; $display("FAIL rst_after_latency: got %0d want 10", lat); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_back_to_back();
      test_wrap();
      test_ignored_start();
      test_reset_mid_calc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
